status_panel_renderer: RTL and testbench

- Parametrised successor to the fixed four-band greenhouse VGA panel. Renders NUM_CH horizontal channel rows, each with a divider, a status block driven by a latching alarm FSM, and a value bar graph with a setpoint marker.
- Consumes pixel coordinates from the 640x480 timing generator and drives registered 24-bit RGB.
- Samples all channel data once per frame so the picture never tears.

---
 rtl/panel_pkg.sv | 22 ++
 rtl/channel_alarm_fsm.sv | 51 +++++
 rtl/status_panel_renderer.sv | 145 ++++++++++++++
 tb/tb_status_panel_renderer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// panel_pkg: shared status codes, alarm FSM encoding and colour constants
// for the status panel renderer.
package panel_pkg;
    typedef enum logic [1:0] {
        ST_OFFLINE = 2'b00,
        ST_OK      = 2'b01,
        ST_ALARM   = 2'b10,
        ST_FAULT   = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        NORMAL      = 2'b00,
        ALARM_UNACK = 2'b01,
        ALARM_ACK   = 2'b10
    } fsm_t;

    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;
endpackage

// File: rtl/channel_alarm_fsm.sv
// channel_alarm_fsm: per-channel frame snapshot, ack capture and latching
// alarm state machine; everything advances only on frame_start.
module channel_alarm_fsm
    import panel_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       ack,
    input  logic [7:0] value_in,
    input  logic [7:0] setpoint_in,
    input  logic [1:0] status_in,
    output logic [7:0] value,
    output logic [7:0] setpoint,
    output logic [1:0] status,
    output fsm_t       state,
    output logic       unack_next
);
    logic ack_pend;
    logic ack_eff;
    logic alarm;
    fsm_t nxt;

    // an ack landing on the frame_start cycle itself still counts for this frame
    always_comb begin
        ack_eff    = ack_pend | ack;
        alarm      = status_in[1];
        nxt        = (state == NORMAL)      ? (alarm ? ALARM_UNACK : NORMAL) :
                     (state == ALARM_UNACK) ? (ack_eff ? (alarm ? ALARM_ACK : NORMAL) : ALARM_UNACK) :
                                              (alarm ? ALARM_ACK : NORMAL);
        unack_next = (nxt == ALARM_UNACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_pend <= 1'b0;
            value    <= '0;
            setpoint <= '0;
            status   <= '0;
            state    <= NORMAL;
        end else begin
            ack_pend <= frame_start ? 1'b0 : ack_eff;
            if (frame_start) begin
                value    <= value_in;
                setpoint <= setpoint_in;
                status   <= status_in;
                state    <= nxt;
            end
        end
    end
endmodule

// File: rtl/status_panel_renderer.sv
// status_panel_renderer: draws NUM_CH channel rows (divider, alarm status block,
// value bar with setpoint marker) through a 2-stage PIX_CE pixel pipeline.
module status_panel_renderer
    import panel_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int V_ACTIVE     = 480,
    parameter int DIV_THICK    = 10,
    parameter int STATUS_X     = 20,
    parameter int STATUS_W     = 60,
    parameter int BAR_X        = 100,
    parameter int BAR_SHIFT    = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  PIX_CE,
    input  logic [9:0]            PIX_X,
    input  logic [9:0]            PIX_Y,
    input  logic                  PIX_VALID,
    input  logic                  FRAME_START,
    input  logic [8*NUM_CH-1:0]   CH_VALUE,
    input  logic [8*NUM_CH-1:0]   CH_SETPOINT,
    input  logic [2*NUM_CH-1:0]   CH_STATUS,
    input  logic [NUM_CH-1:0]     CH_ACK,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  ALARM_ANY
);
    localparam int ROW_H = V_ACTIVE / NUM_CH;
    localparam int RW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0]   Y_END  = 11'(NUM_CH * ROW_H);
    localparam logic [10:0]   S_X0   = 11'(STATUS_X);
    localparam logic [10:0]   S_X1   = 11'(STATUS_X + STATUS_W);
    localparam logic [10:0]   S_Y0   = 11'd16;
    localparam logic [10:0]   S_Y1   = 11'(ROW_H - 16);
    localparam logic [10:0]   B_Y0   = 11'(ROW_H / 2 - 8);
    localparam logic [10:0]   B_Y1   = 11'(ROW_H / 2 + 8);
    localparam logic [10:0]   B_X    = 11'(BAR_X);
    localparam logic [10:0]   D_T    = 11'(DIV_THICK);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

    logic [7:0]        val [NUM_CH];
    logic [7:0]        sp  [NUM_CH];
    logic [1:0]        st  [NUM_CH];
    fsm_t              fsm [NUM_CH];
    logic [NUM_CH-1:0] unack_next;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        channel_alarm_fsm u_fsm (
            .clk         (CLOCK_50),
            .rst_n       (RESET_N),
            .frame_start (FRAME_START),
            .ack         (CH_ACK[i]),
            .value_in    (CH_VALUE[8*i +: 8]),
            .setpoint_in (CH_SETPOINT[8*i +: 8]),
            .status_in   (CH_STATUS[2*i +: 2]),
            .value       (val[i]),
            .setpoint    (sp[i]),
            .status      (st[i]),
            .state       (fsm[i]),
            .unack_next  (unack_next[i])
        );
    end

    logic [RW-1:0] row_d, row1;
    logic [10:0]   base_d, ly_d, x_d, x1;
    logic          y_in, div_d, stat_d, band_d;
    logic          v1, div1, stat1, band1;
    logic [10:0]   bar_end, mark;
    logic          bar_hit, mark_hit;
    logic [1:0]    st_sel;
    fsm_t          fsm_sel;
    logic [23:0]   stat_col, rgb_d, rgb;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    // row decode: the highest row base not above PIX_Y wins, no divider needed
    always_comb begin
        row_d  = '0;
        base_d = '0;
        for (int r = 1; r < NUM_CH; r++)
            if ({1'b0, PIX_Y} >= 11'(r * ROW_H)) begin
                row_d  = RW'(r);
                base_d = 11'(r * ROW_H);
            end
        x_d    = {1'b0, PIX_X};
        ly_d   = {1'b0, PIX_Y} - base_d;
        y_in   = {1'b0, PIX_Y} < Y_END;
        div_d  = y_in && row_d != '0 && ly_d < D_T;
        stat_d = y_in && x_d >= S_X0 && x_d < S_X1 && ly_d >= S_Y0 && ly_d < S_Y1;
        band_d = y_in && ly_d >= B_Y0 && ly_d < B_Y1;
    end

    always_comb begin
        st_sel   = st[row1];
        fsm_sel  = fsm[row1];
        bar_end  = B_X + (11'(val[row1]) << BAR_SHIFT);
        mark     = B_X + (11'(sp[row1]) << BAR_SHIFT);
        bar_hit  = band1 && x1 >= B_X && x1 < bar_end;
        mark_hit = band1 && mark <= x1 + 11'd1 && x1 <= mark + 11'd1;
        stat_col = (st_sel == ST_OFFLINE)    ? BLACK :
                   (fsm_sel == ALARM_ACK)    ? RED :
                   (fsm_sel == ALARM_UNACK)  ? (phase ? RED : WHITE) :
                   (st_sel == ST_OK)         ? GREEN : RED;
        rgb_d    = (!v1 || div1 || mark_hit) ? BLACK :
                   stat1                     ? stat_col :
                   bar_hit                   ? BLUE : WHITE;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            row1      <= '0;
            x1        <= '0;
            v1        <= 1'b0;
            div1      <= 1'b0;
            stat1     <= 1'b0;
            band1     <= 1'b0;
            rgb       <= BLACK;
            blink_cnt <= '0;
            phase     <= 1'b0;
            ALARM_ANY <= 1'b0;
        end else begin
            if (FRAME_START) begin
                blink_cnt <= (blink_cnt == B_LAST) ? '0 : blink_cnt + 1'b1;
                phase     <= (blink_cnt == B_LAST) ? ~phase : phase;
                ALARM_ANY <= |unack_next;
            end
            if (PIX_CE) begin
                row1  <= row_d;
                x1    <= x_d;
                v1    <= PIX_VALID;
                div1  <= div_d;
                stat1 <= stat_d;
                band1 <= band_d;
                rgb   <= rgb_d;
            end
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb;
endmodule

// File: tb/tb_status_panel_renderer.sv
// tb_status_panel_renderer: directed table and sequence checks of the panel
// renderer with default parameters (4 rows of 120 lines).
module tb_status_panel_renderer;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        valid = 1'b0;
    logic        fs = 1'b0;
    logic [9:0]  px = '0;
    logic [9:0]  py = '0;
    logic [31:0] value = '0;
    logic [31:0] setpoint = '0;
    logic [7:0]  status = '0;
    logic [3:0]  ack = '0;
    logic [7:0]  r, g, b;
    logic        any;
    logic [23:0] rgb;

    int n_run = 0;
    int n_fail = 0;
    int frames = 0;

    typedef struct {
        string       name;
        int          x;
        int          y;
        bit          v;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl [20];

    always #10 clk = ~clk;

    status_panel_renderer dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .PIX_CE      (ce),
        .PIX_X       (px),
        .PIX_Y       (py),
        .PIX_VALID   (valid),
        .FRAME_START (fs),
        .CH_VALUE    (value),
        .CH_SETPOINT (setpoint),
        .CH_STATUS   (status),
        .CH_ACK      (ack),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .ALARM_ANY   (any)
    );

    assign rgb = {r, g, b};

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input bit c);
        ce = c;
        @(negedge clk);
    endtask

    task automatic show(input int x, input int y, input bit v);
        px = 10'(x);
        py = 10'(y);
        valid = v;
        repeat (3) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    task automatic probe(input string name, input int x, input int y, input bit v, input logic [23:0] exp);
        show(x, y, v);
        check(name, rgb, exp);
    endtask

    task automatic frame();
        fs = 1'b1;
        step(1'b0);
        fs = 1'b0;
        frames++;
    endtask

    // blink model: phase flips every 30 frame starts, starting at 0 (white)
    function automatic logic [23:0] blink();
        return ((frames / 30) % 2 == 1) ? RED : WHITE;
    endfunction

    initial begin
        repeat (4) begin
            step(1'b1);
            step(1'b0);
        end
        check("reset_rgb", rgb, BLACK);
        check("reset_any", 24'(any), 24'd0);
        rst_n = 1'b1;
        step(1'b0);

        probe("rst_offline_blk", 50, 60, 1'b1, BLACK);
        probe("rst_mark_at_100", 101, 60, 1'b1, BLACK);
        probe("rst_no_bar", 102, 60, 1'b1, WHITE);
        probe("rst_no_bar2", 150, 60, 1'b1, WHITE);

        status   = 8'b01_01_01_01;
        value    = {4{8'd50}};
        setpoint = {4{8'd100}};
        frame();
        tbl[0]  = '{"stat_green",    50,  60, 1'b1, GREEN};
        tbl[1]  = '{"bar_mid",       150, 60, 1'b1, BLUE};
        tbl[2]  = '{"bar_start",     100, 60, 1'b1, BLUE};
        tbl[3]  = '{"bar_last",      199, 60, 1'b1, BLUE};
        tbl[4]  = '{"bar_after",     200, 60, 1'b1, WHITE};
        tbl[5]  = '{"mark_left",     299, 60, 1'b1, BLACK};
        tbl[6]  = '{"mark_center",   300, 60, 1'b1, BLACK};
        tbl[7]  = '{"mark_right",    301, 60, 1'b1, BLACK};
        tbl[8]  = '{"mark_out",      302, 60, 1'b1, WHITE};
        tbl[9]  = '{"white_303",     303, 60, 1'b1, WHITE};
        tbl[10] = '{"div_top",       150, 120, 1'b1, BLACK};
        tbl[11] = '{"div_last",      400, 129, 1'b1, BLACK};
        tbl[12] = '{"div_after",     400, 130, 1'b1, WHITE};
        tbl[13] = '{"row0_no_div",   400, 5,  1'b1, WHITE};
        tbl[14] = '{"invalid_black", 50,  60, 1'b0, BLACK};
        tbl[15] = '{"row1_green",    50,  180, 1'b1, GREEN};
        tbl[16] = '{"stat_y_top",    50,  16, 1'b1, GREEN};
        tbl[17] = '{"stat_y_above",  50,  15, 1'b1, WHITE};
        tbl[18] = '{"stat_x_end",    80,  60, 1'b1, WHITE};
        tbl[19] = '{"below_rows",    150, 485, 1'b1, WHITE};
        for (int i = 0; i < 20; i++)
            probe(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].exp);
        probe("stat_y_bottom", 50, 103, 1'b1, GREEN);
        probe("stat_y_past", 50, 104, 1'b1, WHITE);
        check("any_idle", 24'(any), 24'd0);

        status = 8'b01_01_10_01;
        fs = 1'b1;
        check("any_before_edge", 24'(any), 24'd0);
        step(1'b0);
        fs = 1'b0;
        frames++;
        check("any_after_edge", 24'(any), 24'd1);
        while (frames < 62) begin
            probe("ch1_blink", 50, 180, 1'b1, blink());
            frame();
        end

        ack = 4'b0010;
        step(1'b0);
        ack = 4'b0000;
        check("ack_pending_any", 24'(any), 24'd1);
        probe("ack_pending_blink", 50, 180, 1'b1, blink());
        frame();
        check("acked_any", 24'(any), 24'd0);
        probe("acked_red", 50, 180, 1'b1, RED);
        status = 8'b01_01_01_01;
        frame();
        probe("ch1_cleared", 50, 180, 1'b1, GREEN);

        status = 8'b01_10_01_01;
        frame();
        check("ch2_any", 24'(any), 24'd1);
        status = 8'b01_01_01_01;
        frame();
        check("ch2_latched_any", 24'(any), 24'd1);
        probe("ch2_latched", 50, 300, 1'b1, blink());
        ack = 4'b0100;
        step(1'b0);
        ack = 4'b0000;
        frame();
        check("ch2_ack_any", 24'(any), 24'd0);
        probe("ch2_normal", 50, 300, 1'b1, GREEN);

        status = 8'b10_01_01_01;
        frame();
        check("ch3_any", 24'(any), 24'd1);
        fs  = 1'b1;
        ack = 4'b1000;
        step(1'b0);
        fs  = 1'b0;
        ack = 4'b0000;
        frames++;
        check("ch3_same_cycle_any", 24'(any), 24'd0);
        probe("ch3_same_cycle_red", 50, 420, 1'b1, RED);
        status = 8'b01_01_01_01;
        frame();
        probe("ch3_green", 50, 420, 1'b1, GREEN);

        value[7:0] = 8'd200;
        probe("val_held", 250, 60, 1'b1, WHITE);
        frame();
        probe("val_new", 250, 60, 1'b1, BLUE);
        probe("val_end", 499, 60, 1'b1, BLUE);
        probe("val_past", 500, 60, 1'b1, WHITE);
        probe("val_mark", 300, 60, 1'b1, BLACK);

        probe("lat_pre", 550, 60, 1'b1, WHITE);
        px = 10'd150;
        step(1'b1);
        check("lat_ce1", rgb, WHITE);
        step(1'b0);
        check("lat_idle", rgb, WHITE);
        step(1'b1);
        check("lat_ce2", rgb, BLUE);

        status = 8'b01_01_01_10;
        frame();
        probe("pre_reset_blue", 150, 60, 1'b1, BLUE);
        check("pre_reset_any", 24'(any), 24'd1);
        rst_n = 1'b0;
        #2;
        check("async_rgb", rgb, BLACK);
        check("async_any", 24'(any), 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frames = 0;
        status = 8'b01_01_01_01;
        probe("post_rst_offline", 50, 60, 1'b1, BLACK);
        probe("post_rst_nobar", 150, 60, 1'b1, WHITE);
        check("post_rst_any", 24'(any), 24'd0);
        frame();
        probe("post_rst_ch0", 50, 60, 1'b1, GREEN);
        probe("post_rst_ch3", 50, 420, 1'b1, GREEN);
        check("post_rst_any2", 24'(any), 24'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
